// File: rtl/pcie_merge.sv
// Two-source merge with two input FIFOs and one output FIFO.
// A round-robin arbiter moves words into the output FIFO; the consumer pops registered words.
module pcie_merge #(
    parameter int unsigned BITNUMBER = 6,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CW        = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITNUMBER-1:0] data_in0,
    input  logic                 push0,
    input  logic [BITNUMBER-1:0] data_in1,
    input  logic                 push1,
    input  logic                 pop,
    input  logic [CW-1:0]        umbral,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    output logic                 src_out,
    output logic                 can_pop,
    output logic                 pause0,
    output logic                 pause1,
    output logic                 error
);
    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam int unsigned   OW       = BITNUMBER + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Input FIFOs, indexed by source number
    logic [BITNUMBER-1:0] in_mem_q  [2][DEPTH];
    logic [AW-1:0]        in_wptr_q [2];
    logic [AW-1:0]        in_wptr_d [2];
    logic [AW-1:0]        in_rptr_q [2];
    logic [AW-1:0]        in_rptr_d [2];
    logic [CW-1:0]        in_cnt_q  [2];
    logic [CW-1:0]        in_cnt_d  [2];
    logic [BITNUMBER-1:0] in_din    [2];
    logic [1:0]           in_push;
    logic [1:0]           in_wr;
    logic [1:0]           in_rd;
    logic [1:0]           in_elig;

    // Output FIFO entries are {src, word}
    logic [OW-1:0]        of_mem_q [DEPTH];
    logic [AW-1:0]        of_wptr_q, of_wptr_d;
    logic [AW-1:0]        of_rptr_q, of_rptr_d;
    logic [CW-1:0]        of_cnt_q, of_cnt_d;
    logic [OW-1:0]        of_wdata;
    logic [OW-1:0]        of_head;
    logic                 of_wr;
    logic                 of_rd;

    logic                 last_grant_q, last_grant_d;
    logic [BITNUMBER-1:0] data_out_q, data_out_d;
    logic                 src_out_q, src_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 error_q, error_d;
    logic                 overflow;
    logic                 underflow;

    // NOTE: every signal gets a default first so no latch can be inferred.
    always_comb begin
        in_push   = {push1, push0};
        in_din[0] = data_in0;
        in_din[1] = data_in1;
        in_wr     = '0;
        in_elig   = '0;
        overflow  = 1'b0;
        for (int n = 0; n < 2; n++) begin
            in_elig[n] = (in_cnt_q[n] != '0);
            // Fullness uses the pre-edge count, so a same-edge drain does not make room.
            in_wr[n]   = in_push[n] && (in_cnt_q[n] < CNT_FULL);
            overflow   = overflow | (in_push[n] && !(in_cnt_q[n] < CNT_FULL));
        end
    end

    // Arbiter: the source not granted last time wins a tie; a pop never frees room this cycle.
    always_comb begin
        in_rd        = '0;
        last_grant_d = last_grant_q;
        if (of_cnt_q < CNT_FULL) begin
            if (in_elig[0] && (!in_elig[1] || last_grant_q)) begin
                in_rd[0] = 1'b1;
            end else if (in_elig[1]) begin
                in_rd[1] = 1'b1;
            end
        end
        if (in_rd[0]) last_grant_d = 1'b0;
        if (in_rd[1]) last_grant_d = 1'b1;
        of_wr    = |in_rd;
        of_wdata = in_rd[1] ? {1'b1, in_mem_q[1][in_rptr_q[1]]}
                            : {1'b0, in_mem_q[0][in_rptr_q[0]]};
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            in_wptr_d[n] = in_wptr_q[n];
            in_rptr_d[n] = in_rptr_q[n];
            in_cnt_d[n]  = in_cnt_q[n];
            if (in_wr[n]) in_wptr_d[n] = in_wptr_q[n] + PTR_ONE;
            if (in_rd[n]) in_rptr_d[n] = in_rptr_q[n] + PTR_ONE;
            if (in_wr[n] && !in_rd[n]) begin
                in_cnt_d[n] = in_cnt_q[n] + CNT_ONE;
            end else if (!in_wr[n] && in_rd[n]) begin
                in_cnt_d[n] = in_cnt_q[n] - CNT_ONE;
            end
        end
    end

    always_comb begin
        of_head     = of_mem_q[of_rptr_q];
        of_rd       = pop && (of_cnt_q != '0);
        underflow   = pop && (of_cnt_q == '0);
        of_wptr_d   = of_wptr_q;
        of_rptr_d   = of_rptr_q;
        of_cnt_d    = of_cnt_q;
        if (of_wr) of_wptr_d = of_wptr_q + PTR_ONE;
        if (of_rd) of_rptr_d = of_rptr_q + PTR_ONE;
        if (of_wr && !of_rd) begin
            of_cnt_d = of_cnt_q + CNT_ONE;
        end else if (!of_wr && of_rd) begin
            of_cnt_d = of_cnt_q - CNT_ONE;
        end
        data_out_d  = data_out_q;
        src_out_d   = src_out_q;
        valid_out_d = of_rd;
        if (of_rd) {src_out_d, data_out_d} = of_head;
        error_d     = error_q | overflow | underflow;
    end

    // NOTE: sequential state uses nonblocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                in_wptr_q[n] <= '0;
                in_rptr_q[n] <= '0;
                in_cnt_q[n]  <= '0;
            end
            of_wptr_q    <= '0;
            of_rptr_q    <= '0;
            of_cnt_q     <= '0;
            last_grant_q <= 1'b1;
            data_out_q   <= '0;
            src_out_q    <= 1'b0;
            valid_out_q  <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                in_wptr_q[n] <= in_wptr_d[n];
                in_rptr_q[n] <= in_rptr_d[n];
                in_cnt_q[n]  <= in_cnt_d[n];
            end
            of_wptr_q    <= of_wptr_d;
            of_rptr_q    <= of_rptr_d;
            of_cnt_q     <= of_cnt_d;
            last_grant_q <= last_grant_d;
            data_out_q   <= data_out_d;
            src_out_q    <= src_out_d;
            valid_out_q  <= valid_out_d;
            error_q      <= error_d;
        end
    end

    // NOTE: storage arrays carry no reset; pointers and counts alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (in_wr[n]) in_mem_q[n][in_wptr_q[n]] <= in_din[n];
        end
        if (of_wr) of_mem_q[of_wptr_q] <= of_wdata;
    end

    assign data_out  = data_out_q;
    assign src_out   = src_out_q;
    assign valid_out = valid_out_q;
    assign error     = error_q;
    assign can_pop   = (of_cnt_q != '0);
    assign pause0    = (in_cnt_q[0] >= umbral);
    assign pause1    = (in_cnt_q[1] >= umbral);

endmodule

// File: tb/tb_pcie_merge.sv
// Directed self-checking bench for pcie_merge: reset, basic path, fairness, streaming,
// underflow, overflow with backpressure and asynchronous mid-run reset.
module tb_pcie_merge;
    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [5:0] data_in0 = '0;
    logic [5:0] data_in1 = '0;
    logic       push0    = 1'b0;
    logic       push1    = 1'b0;
    logic       pop      = 1'b0;
    logic [2:0] umbral   = 3'd3;
    logic [5:0] data_out;
    logic       valid_out;
    logic       src_out;
    logic       can_pop;
    logic       pause0;
    logic       pause1;
    logic       error;

    int checks = 0;
    int errors = 0;

    pcie_merge #(.BITNUMBER(6), .DEPTH(4), .CW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in0  (data_in0),
        .push0     (push0),
        .data_in1  (data_in1),
        .push1     (push1),
        .pop       (pop),
        .umbral    (umbral),
        .data_out  (data_out),
        .valid_out (valid_out),
        .src_out   (src_out),
        .can_pop   (can_pop),
        .pause0    (pause0),
        .pause1    (pause1),
        .error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push0 = 1'b0;
        push1 = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++; if (data_out !== 6'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        checks++; if (src_out !== 1'b0) begin errors++; $display("FAIL reset_src_out: got %b want 0", src_out); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL reset_can_pop: got %b want 0", can_pop); end
        checks++; if (pause0 !== 1'b0) begin errors++; $display("FAIL reset_pause0: got %b want 0", pause0); end
        checks++; if (pause1 !== 1'b0) begin errors++; $display("FAIL reset_pause1: got %b want 0", pause1); end
        umbral = 3'd0;
        #1;
        checks++; if (pause0 !== 1'b1) begin errors++; $display("FAIL reset_pause0_umbral0: got %b want 1", pause0); end
        checks++; if (pause1 !== 1'b1) begin errors++; $display("FAIL reset_pause1_umbral0: got %b want 1", pause1); end
        umbral = 3'd3;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        data_in0 = 6'h05;
        push0    = 1'b1;
        step();
        push0 = 1'b0;
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL basic_latency: can_pop %b want 0", can_pop); end
        step();
        checks++; if (can_pop !== 1'b1) begin errors++; $display("FAIL basic_can_pop: got %b want 1", can_pop); end
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid_out); end
        checks++; if (data_out !== 6'h05) begin errors++; $display("FAIL basic_data: got %h want 05", data_out); end
        checks++; if (src_out !== 1'b0) begin errors++; $display("FAIL basic_src: got %b want 0", src_out); end
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL basic_empty: can_pop %b want 0", can_pop); end
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", valid_out); end
        checks++; if (data_out !== 6'h05) begin errors++; $display("FAIL basic_data_hold: got %h want 05", data_out); end
    endtask

    task automatic test_fairness();
        logic [5:0] exp_d [4];
        logic       exp_s [4];
        exp_d = '{6'h01, 6'h11, 6'h02, 6'h12};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        data_in0 = 6'h01;
        data_in1 = 6'h11;
        push0    = 1'b1;
        push1    = 1'b1;
        step();
        data_in0 = 6'h02;
        data_in1 = 6'h12;
        step();
        idle_inputs();
        repeat (3) step();
        checks++; if (can_pop !== 1'b1) begin errors++; $display("FAIL fair_can_pop: got %b want 1", can_pop); end
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (data_out !== exp_d[i]) begin errors++; $display("FAIL fair_data[%0d]: got %h want %h", i, data_out, exp_d[i]); end
            checks++; if (src_out !== exp_s[i]) begin errors++; $display("FAIL fair_src[%0d]: got %b want %b", i, src_out, exp_s[i]); end
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL fair_valid[%0d]: got %b want 1", i, valid_out); end
        end
        pop = 1'b0;
        step();
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL fair_drained: can_pop %b want 0", can_pop); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL fair_error: got %b want 0", error); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 22; i++) begin
            push0    = (i < 20);
            data_in0 = 6'(i * 3 + 1);
            pop      = (i >= 2);
            step();
            if (i >= 2) begin
                checks++; if (data_out !== 6'((i - 2) * 3 + 1)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, data_out, 6'((i - 2) * 3 + 1)); end
                checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, valid_out); end
            end
            if (i >= 2 && i <= 20) begin
                checks++; if (can_pop !== 1'b1) begin errors++; $display("FAIL stream_level[%0d]: can_pop %b want 1", i, can_pop); end
            end
        end
        idle_inputs();
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL stream_drained: can_pop %b want 0", can_pop); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL stream_error: got %b want 0", error); end
    endtask

    task automatic test_underflow();
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL under_valid: got %b want 0", valid_out); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL under_error: got %b want 1", error); end
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL under_can_pop: got %b want 0", can_pop); end
        checks++; if (data_out !== 6'h3A) begin errors++; $display("FAIL under_data_hold: got %h want 3A", data_out); end
        data_in0 = 6'h2A;
        push0    = 1'b1;
        step();
        push0 = 1'b0;
        step();
        checks++; if (can_pop !== 1'b1) begin errors++; $display("FAIL under_refill: can_pop %b want 1", can_pop); end
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (data_out !== 6'h2A) begin errors++; $display("FAIL under_data: got %h want 2A", data_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL under_valid2: got %b want 1", valid_out); end
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL under_empty: can_pop %b want 0", can_pop); end
    endtask

    task automatic test_overflow();
        logic       exp_pause [5];
        logic       exp_err   [5];
        logic [5:0] exp_d     [8];
        logic       exp_s     [8];
        logic       exp_p     [8];
        exp_pause = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_err   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_d     = '{6'h30, 6'h31, 6'h32, 6'h33, 6'h01, 6'h02, 6'h03, 6'h04};
        exp_s     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_p     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        umbral = 3'd3;
        push1  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in1 = 6'(48 + i);
            step();
        end
        push1 = 1'b0;
        step();
        checks++; if (can_pop !== 1'b1) begin errors++; $display("FAIL ovf_of_full: can_pop %b want 1", can_pop); end
        checks++; if (pause1 !== 1'b0) begin errors++; $display("FAIL ovf_pause1: got %b want 0", pause1); end
        push0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in0 = 6'(i + 1);
            step();
            checks++; if (pause0 !== exp_pause[i]) begin errors++; $display("FAIL ovf_pause0[%0d]: got %b want %b", i, pause0, exp_pause[i]); end
            checks++; if (error !== exp_err[i]) begin errors++; $display("FAIL ovf_error[%0d]: got %b want %b", i, error, exp_err[i]); end
        end
        push0 = 1'b0;
        pop   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (data_out !== exp_d[i]) begin errors++; $display("FAIL ovf_data[%0d]: got %h want %h", i, data_out, exp_d[i]); end
            checks++; if (src_out !== exp_s[i]) begin errors++; $display("FAIL ovf_src[%0d]: got %b want %b", i, src_out, exp_s[i]); end
            checks++; if (pause0 !== exp_p[i]) begin errors++; $display("FAIL ovf_drain_pause0[%0d]: got %b want %b", i, pause0, exp_p[i]); end
        end
        pop = 1'b0;
        step();
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL ovf_dropped: can_pop %b want 0", can_pop); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ovf_valid_end: got %b want 0", valid_out); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", error); end
    endtask

    task automatic test_midrun_reset();
        push0 = 1'b1;
        push1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in0 = 6'(10 + i);
            data_in1 = 6'(33 + i);
            pop      = (i == 3);
            step();
        end
        idle_inputs();
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", valid_out); end
        checks++; if (data_out !== 6'h21) begin errors++; $display("FAIL mid_pre_data: got %h want 21", data_out); end
        checks++; if (src_out !== 1'b1) begin errors++; $display("FAIL mid_pre_src: got %b want 1", src_out); end
        checks++; if (pause0 !== 1'b1) begin errors++; $display("FAIL mid_pre_pause0: got %b want 1", pause0); end
        #2 reset = 1'b0;
        #1;
        checks++; if (data_out !== 6'h00) begin errors++; $display("FAIL mid_data: got %h want 00", data_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid_out); end
        checks++; if (src_out !== 1'b0) begin errors++; $display("FAIL mid_src: got %b want 0", src_out); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL mid_error: got %b want 0", error); end
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL mid_can_pop: got %b want 0", can_pop); end
        checks++; if (pause0 !== 1'b0) begin errors++; $display("FAIL mid_pause0: got %b want 0", pause0); end
        checks++; if (pause1 !== 1'b0) begin errors++; $display("FAIL mid_pause1: got %b want 0", pause1); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL mid_release_can_pop: got %b want 0", can_pop); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_release_valid: got %b want 0", valid_out); end
        data_in0 = 6'h15;
        push0    = 1'b1;
        step();
        push0 = 1'b0;
        step();
        checks++; if (can_pop !== 1'b1) begin errors++; $display("FAIL mid_new_can_pop: got %b want 1", can_pop); end
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (data_out !== 6'h15) begin errors++; $display("FAIL mid_new_data: got %h want 15", data_out); end
        checks++; if (src_out !== 1'b0) begin errors++; $display("FAIL mid_new_src: got %b want 0", src_out); end
        step();
        checks++; if (can_pop !== 1'b0) begin errors++; $display("FAIL mid_no_stale: can_pop %b want 0", can_pop); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_stream();
        test_underflow();
        test_overflow();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_merge.md
PCIE_MERGE -- requirements
Module: pcie_merge

Interface
REQ-001 SHALL have parameter BITNUMBER, default 6, giving the data word width.
REQ-002 SHALL have parameter DEPTH, default 4, giving the entries per internal FIFO (power of 2).
REQ-003 SHALL have parameter CW, default 3, giving the occupancy count width (log2(DEPTH)+1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data_in0, input, BITNUMBER bits: source-0 word.
REQ-007 SHALL have port push0, input, 1 bit: write data_in0 into input FIFO 0.
REQ-008 SHALL have port data_in1, input, BITNUMBER bits: source-1 word.
REQ-009 SHALL have port push1, input, 1 bit: write data_in1 into input FIFO 1.
REQ-010 SHALL have port pop, input, 1 bit: consumer read request on the output FIFO.
REQ-011 SHALL have port umbral, input, CW bits: almost-full threshold for the pause outputs.
REQ-012 SHALL have port data_out, output, BITNUMBER bits: merged word.
REQ-013 SHALL have port valid_out, output, 1 bit: data_out holds a word popped the previous cycle.
REQ-014 SHALL have port src_out, output, 1 bit: source index (0/1) of the word on data_out.
REQ-015 SHALL have port can_pop, output, 1 bit: output FIFO non-empty.
REQ-016 SHALL have ports pause0 and pause1, output, 1 bit each: backpressure to source 0/1.
REQ-017 SHALL have port error, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-018 SHALL keep three FIFOs (IF0, IF1, OF) of DEPTH entries, each with its own wrapping read/write pointers and a CW-bit count; OF entries store {src, word}.
REQ-019 SHALL write IF0 on push0 when count0 < DEPTH, with fullness judged on the pre-edge count even if the same edge drains an entry; a push to a full FIFO SHALL drop the word and set error. IF1/push1 behave identically.
REQ-020 SHALL drive pause0 = (count0 >= umbral) and pause1 = (count1 >= umbral), combinationally from the registered counts; umbral = 0 SHALL hold pause asserted.
REQ-021 SHALL run a transfer arbiter: at most one word moves from IF0 or IF1 into OF per cycle, and only while OF count < DEPTH.
REQ-022 SHALL make IFn eligible when countn > 0; with one eligible FIFO it wins, with both eligible the one not in register last_grant wins.
REQ-023 SHALL update last_grant to the winner on every transfer and leave it unchanged on idle cycles.
REQ-024 SHALL make a transferred word poppable from OF one cycle after it leaves IFn (transfer latency 1 clk).
REQ-025 SHALL preserve per-source order; interleaving between sources is set only by the arbiter.
REQ-026 SHALL drive can_pop = (OF count > 0).
REQ-027 SHALL, on pop with can_pop = 1, register the head of OF into data_out/src_out and set valid_out = 1 on the next cycle.
REQ-028 SHALL deassert valid_out on any cycle with no accepted pop, with data_out/src_out holding their last values.
REQ-029 SHALL ignore pop with can_pop = 0, leaving pointers unchanged, and set error.
REQ-030 SHALL perform a same-cycle OF write (transfer) and read (pop) both, leaving the count unchanged; on the full-OF case, a pop does not enable a same-cycle transfer.
REQ-031 SHALL keep error set from when it sets until reset.
REQ-032 SHALL wrap pointers modulo DEPTH with no bubble.

Reset
REQ-033 SHALL, with reset = 0, immediately clear all pointers and counts, data_out = 0, src_out = 0, valid_out = 0, error = 0, and set last_grant = 1 so source 0 wins the first contention.
REQ-034 SHALL, given the above, drive can_pop = 0 in reset, with pause0 = pause1 = 1 only if umbral = 0.
REQ-035 SHALL discard FIFO contents on reset asserted mid-operation, with no partial transfer completing.
REQ-036 SHALL accept push/pop starting the first rising edge after reset returns to 1.

Verification
REQ-037 SHALL cover basic path: push0 of 6'h05, pop when can_pop -> valid_out = 1 one cycle after pop, data_out = 6'h05, src_out = 0.
REQ-038 SHALL cover fairness: preload IF0 = {01,02}, IF1 = {11,12}, no pop until OF full -> popped order 01,11,02,12 with src 0,1,0,1.
REQ-039 SHALL cover overflow: with umbral = 3 and OF kept full (no pop), push0 5 words -> pause0 = 1 once count0 = 3, 5th word dropped, error = 1, 4 words later popped.
REQ-040 SHALL cover underflow: pop on empty -> valid_out = 0, error = 1, no pointer change.
REQ-041 SHALL cover steady stream: continuous push0 and pop for 20 cycles -> output sequence identical, OF count constant, error = 0.
REQ-042 SHALL cover mid-run reset: reset pulsed low with all FIFOs partly full -> all outputs at reset values asynchronously, can_pop = 0 after release.
